exc_sequencer: RTL and testbench

EXC_SEQUENCER -- requirements
Module: exc_sequencer

---
 rtl/exc_sequencer_pkg.sv | 28 ++
 rtl/exc_sequencer_if.sv | 31 +++
 rtl/cp0_regfile.sv | 74 +++++++
 rtl/exc_sequencer.sv | 93 +++++++++
 tb/tb_exc_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exc_sequencer_pkg.sv
// Shared exception codes, address map and CP0 register numbers for the
// exception/interrupt sequencer and its CP0 register file.
package exc_sequencer_pkg;

   typedef logic [6:2] exc_code_t;

   typedef enum logic {
      ST_IDLE,
      ST_FLUSH
   } state_e;

   // Exception codes; EXC_CODE_DEFAULT marks "no exception in this slot".
   localparam exc_code_t EXC_CODE_DEFAULT = 5'd31;
   localparam exc_code_t EXC_INT          = 5'd0;
   localparam exc_code_t EXC_ADEL         = 5'd4;
   localparam exc_code_t EXC_ADES         = 5'd5;
   localparam exc_code_t EXC_RI           = 5'd10;
   localparam exc_code_t EXC_OV           = 5'd12;

   localparam logic [31:0] TEXT_BASE    = 32'h0000_3000;
   localparam logic [31:0] HANDLER_BASE = 32'h0000_4180;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

endpackage

// File: rtl/exc_sequencer_if.sv
// M-stage exception/CP0 bundle between the pipeline (master) and the
// exception sequencer (slave).
interface exc_sequencer_if;
   import exc_sequencer_pkg::*;

   logic        ValidM;
   logic [31:0] PCM;
   logic        BDM;
   exc_code_t   ExcCodeM;
   logic        EretM;
   logic [7:2]  HWInt;
   logic        CP0WeM;
   logic [4:0]  CP0AddrM;
   logic [31:0] CP0WdM;
   logic [31:0] CP0Rd;
   logic        ExcTakeM;
   logic        FlushAll;
   logic        PCRedirect;
   logic [31:0] PCTarget;

   modport master (
      output ValidM, PCM, BDM, ExcCodeM, EretM, HWInt, CP0WeM, CP0AddrM, CP0WdM,
      input  CP0Rd, ExcTakeM, FlushAll, PCRedirect, PCTarget
   );

   modport slave (
      input  ValidM, PCM, BDM, ExcCodeM, EretM, HWInt, CP0WeM, CP0AddrM, CP0WdM,
      output CP0Rd, ExcTakeM, FlushAll, PCRedirect, PCTarget
   );

endinterface

// File: rtl/cp0_regfile.sv
// CP0 SR/Cause/EPC storage plus the MFC0 read mux. Exception entry wins over
// ERET, which wins over MTC0; the sequencer already gates all three by state.
module cp0_regfile
   import exc_sequencer_pkg::*;
#(
   parameter logic [31:0] PRID_VALUE = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:2]  hw_int,
   input  logic        take,
   input  logic [31:0] take_epc,
   input  logic        take_bd,
   input  exc_code_t   take_code,
   input  logic        eret,
   input  logic        mtc0_en,
   input  logic [4:0]  addr,
   input  logic [31:0] wd,
   output logic        ie,
   output logic        exl,
   output logic [15:10] im,
   output logic [31:0] epc,
   output logic [31:0] rd
);

   logic        bd;
   logic [15:10] ip;
   exc_code_t   exc_code;

   always_ff @(posedge clk) begin
      if (reset) begin
         ie       <= 1'b0;
         exl      <= 1'b0;
         im       <= '0;
         epc      <= '0;
         bd       <= 1'b0;
         ip       <= '0;
         exc_code <= '0;
      end else begin
         ip <= hw_int;
         if (take) begin
            epc      <= take_epc;
            bd       <= take_bd;
            exc_code <= take_code;
            exl      <= 1'b1;
         end else if (eret) begin
            // A same-cycle MTC0 is dropped so ERET always returns to the old EPC.
            exl <= 1'b0;
         end else if (mtc0_en) begin
            case (addr)
               CP0_SR: begin
                  im  <= wd[15:10];
                  exl <= wd[1];
                  ie  <= wd[0];
               end
               CP0_EPC: epc <= wd;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      rd = '0;
      case (addr)
         CP0_SR:    rd = {16'b0, im, 8'b0, exl, ie};
         CP0_CAUSE: rd = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
         CP0_EPC:   rd = epc;
         CP0_PRID:  rd = PRID_VALUE;
         default:   rd = '0;
      endcase
   end

endmodule

// File: rtl/exc_sequencer.sv
// M-stage exception/interrupt/ERET sequencer: detects the event, updates CP0
// and spends one FLUSH cycle redirecting the PC to the handler or to EPC.
module exc_sequencer
   import exc_sequencer_pkg::*;
#(
   parameter logic [31:0] HANDLER_ADDR = HANDLER_BASE,
   parameter logic [31:0] PRID_VALUE   = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             reset,
   exc_sequencer_if.slave   bus
);

   state_e      state, state_next;
   logic [31:0] target_q, target_next;
   logic        ie, exl;
   logic [15:10] im;
   logic [31:0] epc;
   logic        idle, int_req, exc_req, take, eret, mtc0_en;
   logic [31:0] take_epc;
   exc_code_t   take_code;

   assign idle     = (state == ST_IDLE);
   assign int_req  = ie & ~exl & (|(bus.HWInt & im)) & bus.ValidM;
   assign exc_req  = ~exl & bus.ValidM & (bus.ExcCodeM != EXC_CODE_DEFAULT);
   assign take     = idle & (int_req | exc_req);
   assign eret     = idle & bus.ValidM & bus.EretM & ~take;
   assign mtc0_en  = bus.CP0WeM & idle & ~take;
   assign take_epc = bus.BDM ? bus.PCM - 32'd4 : bus.PCM;
   assign take_code = int_req ? EXC_INT : bus.ExcCodeM;

   assign bus.ExcTakeM = take;

   cp0_regfile #(
      .PRID_VALUE (PRID_VALUE)
   ) u_cp0 (
      .clk       (clk),
      .reset     (reset),
      .hw_int    (bus.HWInt),
      .take      (take),
      .take_epc  (take_epc),
      .take_bd   (bus.BDM),
      .take_code (take_code),
      .eret      (eret),
      .mtc0_en   (mtc0_en),
      .addr      (bus.CP0AddrM),
      .wd        (bus.CP0WdM),
      .ie        (ie),
      .exl       (exl),
      .im        (im),
      .epc       (epc),
      .rd        (bus.CP0Rd)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         target_q <= '0;
      end else begin
         state    <= state_next;
         target_q <= target_next;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next     = state;
      target_next    = target_q;
      bus.FlushAll   = 1'b0;
      bus.PCRedirect = 1'b0;
      bus.PCTarget   = '0;
      case (state)
         ST_IDLE: begin
            if (take) begin
               state_next  = ST_FLUSH;
               target_next = HANDLER_ADDR;
            end else if (eret) begin
               state_next  = ST_FLUSH;
               target_next = epc;
            end
         end
         ST_FLUSH: begin
            bus.FlushAll   = 1'b1;
            bus.PCRedirect = 1'b1;
            bus.PCTarget   = target_q;
            state_next     = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer: expectations are queued as each step is
// driven and compared when the DUT output they describe becomes valid.
module tb_exc_sequencer;
   import exc_sequencer_pkg::*;

   typedef enum {K_TAKE, K_FLUSH, K_REDIR, K_TARGET, K_CP0} kind_e;

   typedef struct {
      string       tag;
      kind_e       kind;
      logic [4:0]  addr;
      logic [31:0] val;
   } exp_t;

   localparam logic [31:0] PRID = 32'h0000_4C01;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   exc_sequencer_if bus ();

   exc_sequencer #(
      .HANDLER_ADDR (32'h0000_4180),
      .PRID_VALUE   (PRID)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input kind_e kind, input logic [31:0] val);
      exp_t e;
      e.tag = tag; e.kind = kind; e.addr = '0; e.val = val;
      sb.push_back(e);
   endtask

   task automatic push_cp0(input string tag, input logic [4:0] addr, input logic [31:0] val);
      exp_t e;
      e.tag = tag; e.kind = K_CP0; e.addr = addr; e.val = val;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] obs;
      while (sb.size() != 0) begin
         e   = sb.pop_front();
         obs = '0;
         case (e.kind)
            K_TAKE:   obs = {31'b0, bus.ExcTakeM};
            K_FLUSH:  obs = {31'b0, bus.FlushAll};
            K_REDIR:  obs = {31'b0, bus.PCRedirect};
            K_TARGET: obs = bus.PCTarget;
            K_CP0: begin
               bus.CP0AddrM = e.addr;
               #1;
               obs = bus.CP0Rd;
            end
            default: obs = 'x;
         endcase
         check(e.tag, obs, e.val);
      end
   endtask

   task automatic idle();
      bus.ValidM   = 1'b0;
      bus.PCM      = '0;
      bus.BDM      = 1'b0;
      bus.ExcCodeM = EXC_CODE_DEFAULT;
      bus.EretM    = 1'b0;
      bus.CP0WeM   = 1'b0;
      bus.CP0AddrM = '0;
      bus.CP0WdM   = '0;
   endtask

   task automatic drive_exc(input logic [31:0] pc, input logic bd, input exc_code_t code);
      bus.ValidM   = 1'b1;
      bus.PCM      = pc;
      bus.BDM      = bd;
      bus.ExcCodeM = code;
   endtask

   task automatic drive_mtc0(input logic [4:0] addr, input logic [31:0] wd);
      bus.CP0WeM   = 1'b1;
      bus.CP0AddrM = addr;
      bus.CP0WdM   = wd;
   endtask

   task automatic drive_eret(input logic [31:0] pc);
      bus.ValidM = 1'b1;
      bus.EretM  = 1'b1;
      bus.PCM    = pc;
   endtask

   // Compare same-cycle expectations shortly after the inputs settle.
   task automatic pre();
      #1;
      drain();
   endtask

   // Cross the rising edge, compare post-edge expectations, return at the falling edge.
   task automatic post();
      @(posedge clk);
      #1;
      idle();
      drain();
      @(negedge clk);
   endtask

   initial begin
      idle();
      bus.HWInt = '0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      push("rst_flush", K_FLUSH, 0);
      push("rst_redir", K_REDIR, 0);
      push("rst_target", K_TARGET, 0);
      push_cp0("rst_sr", CP0_SR, 0);
      push_cp0("rst_cause", CP0_CAUSE, 0);
      push_cp0("rst_epc", CP0_EPC, 0);
      push_cp0("prid", CP0_PRID, PRID);
      push_cp0("unmapped_reg", 5'd5, 0);
      drain();

      // AdEL at 0x3008
      drive_exc(32'h3008, 1'b0, EXC_ADEL);
      push("adel_take", K_TAKE, 1);
      pre();
      push("adel_flush", K_FLUSH, 1);
      push("adel_redir", K_REDIR, 1);
      push("adel_target", K_TARGET, 32'h4180);
      push_cp0("adel_epc", CP0_EPC, 32'h3008);
      push_cp0("adel_cause", CP0_CAUSE, 32'h0000_0010);
      push_cp0("adel_sr", CP0_SR, 32'h0000_0002);
      post();
      push("flush_one_cycle", K_FLUSH, 0);
      push("target_zero_idle", K_TARGET, 0);
      post();

      // EXL set: further exceptions blocked
      drive_exc(32'h3020, 1'b0, EXC_RI);
      push("exl_blocks_take", K_TAKE, 0);
      pre();
      push("exl_blocks_flush", K_FLUSH, 0);
      push_cp0("exl_blocks_epc", CP0_EPC, 32'h3008);
      post();

      // MTC0 EPC, not forwarded to the same-cycle read
      drive_mtc0(CP0_EPC, 32'h3020);
      push_cp0("mtc0_no_forward", CP0_EPC, 32'h3008);
      pre();
      push_cp0("mtc0_epc", CP0_EPC, 32'h3020);
      post();

      // ERET to 0x3020, then an exception during FLUSH is ignored
      drive_eret(32'h3024);
      push("eret_take", K_TAKE, 0);
      pre();
      push("eret_target", K_TARGET, 32'h3020);
      push("eret_redir", K_REDIR, 1);
      push_cp0("eret_sr", CP0_SR, 0);
      post();
      drive_exc(32'h3040, 1'b0, EXC_ADEL);
      push("flush_ignores_exc", K_TAKE, 0);
      pre();
      push("flush_exc_noflush", K_FLUSH, 0);
      push_cp0("flush_exc_epc", CP0_EPC, 32'h3020);
      push_cp0("flush_exc_sr", CP0_SR, 0);
      post();

      // Ov in a branch delay slot
      drive_exc(32'h3010, 1'b1, EXC_OV);
      push("ov_bd_take", K_TAKE, 1);
      pre();
      push("ov_bd_target", K_TARGET, 32'h4180);
      push_cp0("ov_bd_epc", CP0_EPC, 32'h300C);
      push_cp0("ov_bd_cause", CP0_CAUSE, 32'h8000_0030);
      push_cp0("ov_bd_sr", CP0_SR, 32'h0000_0002);
      post();
      drive_eret(32'h4180);
      pre();
      push("flush_ignores_eret", K_FLUSH, 0);
      post();
      drive_eret(32'h4184);
      pre();
      push("eret_bd_target", K_TARGET, 32'h300C);
      post();
      push("eret_bd_done", K_FLUSH, 0);
      post();

      // Exception and MTC0 EPC in the same cycle: MTC0 dropped
      drive_exc(32'h3004, 1'b0, EXC_ADEL);
      drive_mtc0(CP0_EPC, 32'h3100);
      push("coll_take", K_TAKE, 1);
      pre();
      push("coll_target", K_TARGET, 32'h4180);
      push_cp0("coll_epc", CP0_EPC, 32'h3004);
      post();
      post();
      drive_eret(32'h4180);
      pre();
      push("coll_eret_target", K_TARGET, 32'h3004);
      post();
      post();

      // Interrupt enable, pending interrupt held while ValidM=0, then priority over RI
      drive_mtc0(CP0_SR, 32'h0000_0401);
      pre();
      push_cp0("mtc0_sr", CP0_SR, 32'h0000_0401);
      post();
      bus.HWInt = 6'b000001;
      push("int_bubble_no_take", K_TAKE, 0);
      pre();
      push("int_bubble_noflush", K_FLUSH, 0);
      push_cp0("int_ip_sampled", CP0_CAUSE, 32'h0000_0410);
      post();
      drive_exc(32'h3050, 1'b0, EXC_RI);
      push("int_take", K_TAKE, 1);
      pre();
      push("int_target", K_TARGET, 32'h4180);
      push_cp0("int_cause", CP0_CAUSE, 32'h0000_0400);
      push_cp0("int_epc", CP0_EPC, 32'h3050);
      push_cp0("int_sr", CP0_SR, 32'h0000_0403);
      post();
      bus.HWInt = '0;
      pre();
      push_cp0("ip_sampled_in_flush", CP0_CAUSE, 0);
      post();
      drive_eret(32'h4180);
      pre();
      push("int_eret_target", K_TARGET, 32'h3050);
      push_cp0("int_eret_sr", CP0_SR, 32'h0000_0401);
      post();
      post();

      // PCM-4 wraps at zero
      drive_exc(32'h0000_0000, 1'b1, EXC_ADES);
      push("wrap_take", K_TAKE, 1);
      pre();
      push_cp0("wrap_epc", CP0_EPC, 32'hFFFF_FFFC);
      push_cp0("wrap_cause", CP0_CAUSE, 32'h8000_0014);
      post();
      post();

      // ERET with MTC0 to EPC: old EPC used, MTC0 dropped
      drive_eret(32'h4180);
      drive_mtc0(CP0_EPC, 32'h3200);
      push("eret_mtc0_take", K_TAKE, 0);
      pre();
      push("eret_mtc0_target", K_TARGET, 32'hFFFF_FFFC);
      push_cp0("eret_mtc0_epc", CP0_EPC, 32'hFFFF_FFFC);
      push_cp0("eret_mtc0_sr", CP0_SR, 32'h0000_0401);
      post();
      post();

      // Reset during FLUSH, then reset dominating a Take
      drive_exc(32'h3060, 1'b0, EXC_ADEL);
      pre();
      push("pre_reset_flush", K_FLUSH, 1);
      post();
      reset = 1'b1;
      drive_exc(32'h3070, 1'b0, EXC_RI);
      pre();
      push("rst_in_flush_flush", K_FLUSH, 0);
      push("rst_in_flush_redir", K_REDIR, 0);
      push("rst_in_flush_target", K_TARGET, 0);
      push_cp0("rst_in_flush_sr", CP0_SR, 0);
      push_cp0("rst_in_flush_cause", CP0_CAUSE, 0);
      push_cp0("rst_in_flush_epc", CP0_EPC, 0);
      post();
      drive_exc(32'h3080, 1'b0, EXC_ADEL);
      pre();
      push("rst_vs_take_flush", K_FLUSH, 0);
      push_cp0("rst_vs_take_epc", CP0_EPC, 0);
      push_cp0("rst_vs_take_sr", CP0_SR, 0);
      post();
      reset = 1'b0;
      pre();
      push("no_redir_after_rst", K_REDIR, 0);
      post();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
